// File: rtl/imem_program_encoder.sv
// Instruction encoder and loader for the 16-bit MIPS core.
// Packs instruction field requests into 16-bit words and writes them
// sequentially into instruction memory starting at address 0, tracking fill
// level, completion and immediate-range errors.
module imem_program_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [2:0]        rs,
    input  logic [2:0]        rt,
    input  logic [2:0]        rd,
    input  logic [3:0]        funct,
    input  logic [15:0]       imm,
    input  logic [12:0]       target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              wr_en_q;
    logic              accept;
    logic              is_itype;
    logic              imm_bad;
    logic [15:0]       enc_word;

    // Requests are taken only while loading; a start in the same cycle
    // restarts the load and drops the request. Reset also blocks acceptance.
    assign in_ready = (state == LOAD) && !start && !reset;
    assign accept   = in_valid && in_ready;

    // Reset cancels a write that is already on the bus this cycle.
    assign wr_en = wr_en_q && !reset;

    // Field packing and immediate range check for the presented request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enc_word = 16'h0000;
        is_itype = 1'b0;
        case (op)
            3'b000:         enc_word = {op, rs, rt, rd, funct};
            3'b010, 3'b011: enc_word = {op, target};
            default: begin
                enc_word = {op, rs, rt, imm[6:0]};
                is_itype = 1'b1;
            end
        endcase
        // imm must fit in 7 signed bits: the upper ten bits must all match.
        imm_bad = is_itype && !((imm[15:6] == 10'h000) || (imm[15:6] == 10'h3FF));
    end

    // Load FSM, write port, fill tracking and error flag, all registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            wr_en_q <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            count   <= '0;
            full    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done    <= 1'b0;
            if (start) begin
                state <= LOAD;
                addr  <= '0;
                count <= '0;
                err   <= 1'b0;
                full  <= 1'b0;
            end else begin
                if (finish && (state != IDLE)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                // full rises the cycle after the write to the last address.
                if (wr_en_q && (wr_addr == LAST_ADDR)) begin
                    full <= 1'b1;
                end
                if (accept) begin
                    if (imm_bad) begin
                        err <= 1'b1;
                    end else begin
                        wr_en_q <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= enc_word;
                        addr    <= addr + 1'b1;
                        count   <= count + 1'b1;
                        // Stop accepting as soon as the last slot is claimed.
                        if ((addr == LAST_ADDR) && !finish) begin
                            state <= FULL;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Directed self-checking bench for imem_program_encoder. A default-width
// instance covers encoding, handshake and control; a 2-bit address instance
// shares the same inputs and is checked for the fill/FULL behaviour.
module tb_imem_program_encoder;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid;
    logic [2:0]  op, rs, rt, rd;
    logic [3:0]  funct;
    logic [15:0] imm;
    logic [12:0] target;

    logic        in_ready, wr_en, full, done, err;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [8:0]  count;

    logic        s_in_ready, s_wr_en, s_full, s_done, s_err;
    logic [1:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    imem_program_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
        .full(full), .done(done), .err(err)
    );

    imem_program_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .count(s_count),
        .full(s_full), .done(s_done), .err(s_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] o, input logic [2:0] s, input logic [2:0] t,
                           input logic [2:0] d, input logic [3:0] f, input logic [15:0] i,
                           input logic [12:0] tg);
        op = o; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_req(3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 16'd0, 13'd0);
        tick(); tick();
        checks++;
        if ({in_ready, wr_en, full, done, err} !== 5'b0 || wr_addr !== 8'd0 ||
            wr_data !== 16'd0 || count !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b full=%b done=%b err=%b addr=%0d data=%h cnt=%0d, want all 0",
                     in_ready, wr_en, full, done, err, wr_addr, wr_data, count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b want 0", in_ready);
        end
    endtask

    task automatic test_rtype();
        do_start();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: got %b want 1", in_ready);
        end
        set_req(3'b000, 3'd2, 3'd3, 3'd1, 4'd0, 16'h7FFF, 13'd0); // add r1,r2,r3 (imm ignored)
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 16'h0990 || count !== 9'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rtype_write: got we=%b addr=%0d data=%h cnt=%0d err=%b, want 1 0 0990 1 0",
                     wr_en, wr_addr, wr_data, count, err);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || wr_data !== 16'h0990 || wr_addr !== 8'd0) begin
            errors++;
            $display("FAIL rtype_hold: got we=%b addr=%0d data=%h, want 0 0 0990", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        set_req(3'b100, 3'd2, 3'd1, 3'd0, 4'd0, 16'hFFFC, 13'd0); // lw r1,-4(r2)
        in_valid = 1'b1;
        tick();
        set_req(3'b010, 3'd0, 3'd0, 3'd0, 4'd0, 16'h8000, 13'h0010); // j 0x0010, wild imm
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 16'h88FC || count !== 9'd1) begin
            errors++;
            $display("FAIL b2b_first: got we=%b addr=%0d data=%h cnt=%0d, want 1 0 88fc 1",
                     wr_en, wr_addr, wr_data, count);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd1 || wr_data !== 16'h4010 || count !== 9'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got we=%b addr=%0d data=%h cnt=%0d err=%b, want 1 1 4010 2 0",
                     wr_en, wr_addr, wr_data, count, err);
        end
    endtask

    task automatic test_range();
        do_start();
        set_req(3'b111, 3'd0, 3'd0, 3'd0, 4'd0, 16'd64, 13'd0); // addi imm=64: out of range
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL range_ready: got %b want 1", in_ready);
        end
        tick();
        set_req(3'b111, 3'd0, 3'd0, 3'd0, 4'd0, 16'hFFC0, 13'd0); // addi imm=-64
        checks++;
        if (wr_en !== 1'b0 || err !== 1'b1 || count !== 9'd0) begin
            errors++;
            $display("FAIL range_err: got we=%b err=%b cnt=%0d, want 0 1 0", wr_en, err, count);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 16'hE040 || count !== 9'd1 || err !== 1'b1) begin
            errors++;
            $display("FAIL range_edge: got we=%b addr=%0d data=%h cnt=%0d err=%b, want 1 0 e040 1 1",
                     wr_en, wr_addr, wr_data, count, err);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL range_clear: got err=%b cnt=%0d, want 0 0", err, count);
        end
    endtask

    task automatic test_full();
        logic [15:0] exp_word;
        do_start();
        for (int i = 0; i < 5; i++) begin
            set_req(3'b000, 3'd1, 3'd2, 3'(i), 4'(i), 16'd0, 13'd0);
            in_valid = 1'b1;
            #1;
            if (i == 4) begin
                checks++;
                if (s_in_ready !== 1'b0 || s_full !== 1'b0 || s_wr_en !== 1'b1 || s_wr_addr !== 2'd3) begin
                    errors++;
                    $display("FAIL full_last_write: got rdy=%b full=%b we=%b addr=%0d, want 0 0 1 3",
                             s_in_ready, s_full, s_wr_en, s_wr_addr);
                end
            end
            tick();
            if (i < 4) begin
                exp_word = {3'b000, 3'd1, 3'd2, 3'(i), 4'(i)};
                checks++;
                if (s_wr_en !== 1'b1 || s_wr_addr !== 2'(i) || s_wr_data !== exp_word || s_count !== 3'(i + 1)) begin
                    errors++;
                    $display("FAIL full_write%0d: got we=%b addr=%0d data=%h cnt=%0d, want 1 %0d %h %0d",
                             i, s_wr_en, s_wr_addr, s_wr_data, s_count, i, exp_word, i + 1);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (s_wr_en !== 1'b0 || s_full !== 1'b1 || s_count !== 3'd4 || s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got we=%b full=%b cnt=%0d rdy=%b, want 0 1 4 0",
                     s_wr_en, s_full, s_count, s_in_ready);
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        checks++;
        if (s_done !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL finish_done: got small=%b big=%b want 1 1", s_done, done);
        end
        tick();
        checks++;
        if (s_done !== 1'b0 || s_in_ready !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL finish_idle: got done=%b rdy=%b/%b want 0 0 0", s_done, s_in_ready, in_ready);
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle_finish: got done=%b want 0", done);
        end
    endtask

    task automatic test_start_collisions();
        do_start();
        start = 1'b1;
        set_req(3'b000, 3'd4, 3'd5, 3'd6, 4'd7, 16'd0, 13'd0);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ready: got %b want 0", in_ready);
        end
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL start_drop: got we=%b cnt=%0d want 0 0", wr_en, count);
        end
        start = 1'b1;
        finish = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_finish: got done=%b rdy=%b want 0 1", done, in_ready);
        end
    endtask

    task automatic test_reset_inflight();
        do_start();
        set_req(3'b101, 3'd3, 3'd4, 3'd0, 4'd0, 16'h0005, 13'd0); // sw
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_cancel: got we=%b want 0", wr_en);
        end
        tick();
        checks++;
        if ({in_ready, wr_en, full, done, err} !== 5'b0 || wr_addr !== 8'd0 ||
            wr_data !== 16'd0 || count !== 9'd0) begin
            errors++;
            $display("FAIL reset_clear: got rdy=%b we=%b full=%b done=%b err=%b addr=%0d data=%h cnt=%0d, want all 0",
                     in_ready, wr_en, full, done, err, wr_addr, wr_data, count);
        end
        reset = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b we=%b want 0 0", in_ready, wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_range();
        test_full();
        test_start_collisions();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_program_encoder.md
Name: imem_program_encoder

Overview:
Instruction encoder and loader for the 16-bit MIPS core. It is the inverse of the opcode decoder. It accepts instruction field requests over a valid/ready handshake and packs them into 16-bit instruction words. It writes the words sequentially into instruction memory from address 0 and tracks fill level, completion and encoding errors, so test programs and boot images are produced in hardware rather than by hand-assembled hex.

Parameters:
ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W words.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
start  input  1  pulse; begin new program load at address 0.
finish  input  1  pulse; end load, return to IDLE.
in_valid  input  1  request present.
in_ready  output  1  request accepted when in_valid & in_ready.
op  input  3  opcode: 000 R-type, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
rs  input  3  source register.
rt  input  3  second source / destination register.
rd  input  3  R-type destination register.
funct  input  4  R-type function field.
imm  input  16  signed immediate (I-type).
target  input  13  jump target (J-type).
wr_en  output  1  instruction memory write strobe.
wr_addr  output  ADDR_W  write address.
wr_data  output  16  encoded instruction word.
count  output  ADDR_W+1  words written since start.
full  output  1  memory filled.
done  output  1  one-cycle pulse on finish.
err  output  1  sticky immediate-range error.

Behaviour:
- Reset: all outputs 0. State IDLE, internal address 0. Reset overrides start, finish and any in-flight write; the pending wr_en is cancelled.
- States:
  - IDLE: in_ready=0.
  - LOAD: in_ready=1 unless start is high this cycle.
  - FULL: in_ready=0.
- State transitions:
  - start in any state -> LOAD. Address=0, count=0, err=0, full=0. Any request presented that cycle is not accepted.
  - finish in LOAD or FULL -> IDLE, with done=1 for exactly one cycle. start wins over finish in the same cycle. finish in IDLE is ignored; no done pulse.
  - After the write to address 2**ADDR_W-1 -> FULL, with full=1 from the cycle after that write.
- Encoding, by op:
  - R-type (000): {op,rs,rt,rd,funct}.
  - I-type (001,100,101,110,111): {op,rs,rt,imm[6:0]}.
  - J-type (010,011): {op,target}.
- Range check: I-type imm must lie in [-64,63], i.e. imm[15:6] all equal.
  - Violation: the request is accepted (handshake completes), no write occurs, the address and count are unchanged, and err sets and stays set until start or reset.
  - J-type and R-type requests cannot raise err. imm is ignored for them.
- Latency: a transfer in cycle N gives wr_en=1 in cycle N+1, with wr_addr = current address and wr_data = encoded word. The address increments after each write; count increments in the same cycle as the write.
- Throughput: one request per cycle, back-to-back. wr_en stays high on consecutive cycles.
- The last request accepted in LOAD before the transition to FULL still writes in the next cycle.
- wr_data and wr_addr hold their last values when wr_en=0.
- in_valid with in_ready=0 has no effect; the encoder places no requirement on request stability.

Test Plan:
1. reset, start, then add r1,r2,r3: op=000, rs=2, rt=3, rd=1, funct=0 -> next cycle wr_en=1, wr_addr=0, wr_data=0x0990; count=1.
2. lw r1,-4(r2): op=100, rs=2, rt=1, imm=0xFFFC; then j 0x0010: op=010, target=0x0010; back-to-back -> wr_data 0x88FC @addr0 then 0x4010 @addr1 on consecutive cycles, count=2.
3. addi with imm=64 -> handshake completes, no wr_en, err=1, count unchanged; a following addi imm=-64 (op=111, rs=0, rt=0) writes 0xE040 at the same address; a new start clears err.
4. ADDR_W=2: five back-to-back requests -> four writes to addrs 0..3, full=1 and in_ready=0 after the fourth write, fifth not accepted; finish -> done pulse, IDLE.
5. start and in_valid asserted together -> no transfer that cycle; start and finish together -> LOAD, no done pulse.
6. reset asserted in the cycle after a transfer -> wr_en=0 that cycle; all outputs 0; in_ready=0 until the next start.
